pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
- Match-level sequencer for the Pong datapath. It sits between the player buttons and the ball/paddle datapath.
- It owns the match FSM (idle, serve countdown, rally, point pause, game over), the scores and the ball speed level.
- It gates ball motion with game_active and requests ball re-centring through a one-cycle ball_recentre pulse.
- The ball datapath only reports exits through point_p1/point_p2.

Parameters:
- WIN_SCORE, 5: score that ends the match.
- SERVE_FRAMES, 60: frames of countdown before each serve.
- POINT_FRAMES, 30: frames of freeze after a point.
- RAMP_FRAMES, 600: rally frames between speed increments.
- SPEED_MIN, 2: speed at every serve.
- SPEED_MAX, 5: speed ceiling.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- refresh_tick  in  1  one-cycle frame strobe
- start_btn  in  1  synchronised level; rising edge is used
- pause_btn  in  1  synchronised level; rising edge is used (PAUSE_EN only)
- point_p1  in  1  one-cycle pulse: ball left the right edge, player 1 scores
- point_p2  in  1  one-cycle pulse: ball left the left edge, player 2 scores
- game_active  out  1  ball/paddle motion enable
- ball_recentre  out  1  one-cycle pulse: datapath reloads ball to centre
- serve_dir  out  1  0 = serve toward player 1 (left), 1 = toward player 2
- speed_level  out  3  current ball speed
- score_p1  out  4  player 1 score
- score_p2  out  4  player 2 score
- countdown  out  7  frames remaining in SERVE, else 0
- winner  out  2  00 none, 01 player 1, 10 player 2
- state_o  out  3  encoded FSM state for the HUD

Behaviour:
- Reset values:
  - state IDLE; scores 0; speed_level SPEED_MIN; serve_dir 0.
  - countdown 0; winner 00; game_active 0; ball_recentre 0.
  - Edge-detect registers 0.
- All outputs are registered. Transitions take effect on the clk edge after the cause. Frame counters decrement only on cycles with refresh_tick.
- IDLE: on start_btn rising edge -> SERVE. Load countdown with SERVE_FRAMES, pulse ball_recentre, clear scores and winner, set speed SPEED_MIN.
- SERVE:
  - game_active 0. countdown decrements per tick.
  - A tick while countdown==1 -> RALLY, countdown 0, ramp counter 0.
- RALLY:
  - game_active 1. The ramp counter increments per tick.
  - On reaching RAMP_FRAMES, the counter returns to 0 and speed_level increments, saturating at SPEED_MAX. Speed never wraps.
  - point_p1 -> score_p1+1, serve_dir 1 (serve toward the loser).
  - point_p2 -> score_p2+1, serve_dir 0.
  - After either point -> POINT with frame counter POINT_FRAMES.
  - point_p1 and point_p2 in the same cycle: point_p1 wins, point_p2 is dropped.
  - Point pulses outside RALLY are ignored.
- POINT:
  - game_active 0. When the counter expires:
    - If either score ≥ WIN_SCORE -> GAME_OVER, with winner set to the scorer.
    - Otherwise -> SERVE, pulse ball_recentre, speed back to SPEED_MIN, countdown SERVE_FRAMES.
  - The score comparison uses the already-updated score, so the 5th point ends the match.
- GAME_OVER:
  - game_active 0. Scores and winner are held for display.
  - start_btn rising edge -> same actions as from IDLE.
- start_btn in SERVE, RALLY or POINT is ignored.
- Reset asserted mid-operation returns immediately to reset values. No pulse is emitted during reset.
- Score width is 4 bits. WIN_SCORE ≤ 15 is required, so no overflow.
- If SERVE_FRAMES or POINT_FRAMES is 0, the state lasts exactly one tick.

Optional Feature:
- Macro PONG_PAUSE_EN.
- With the macro: pause_btn rising edge in SERVE or RALLY -> PAUSED.
  - The return state is stored; all counters freeze; game_active is 0.
  - The next pause_btn rising edge returns to the stored state with counters intact.
  - Point pulses are ignored while PAUSED.
  - start_btn is ignored while PAUSED.
- Without the macro: the pause_btn port exists but is unused. There is no PAUSED state, and state_o never shows its code (3'd5).

Decomposition:
- Shared package pong_pkg holds:
  - The state enum, encoded IDLE=0, SERVE=1, RALLY=2, POINT=3, GAME_OVER=4, PAUSED=5.
  - The winner codes.
  - The default constants WIN_SCORE, SPEED_MIN and SPEED_MAX, so the ball datapath and HUD share them.
- One natural sub-module, pong_frame_timer: a loadable down-counter advancing on refresh_tick. It has load, value and expire outputs and is reused for serve and point timing.

Test Plan:
- Bench parameters: SERVE_FRAMES=3, POINT_FRAMES=2, RAMP_FRAMES=4, WIN_SCORE=5.
- Start and serve: reset, start_btn edge -> one ball_recentre pulse, countdown 3,2,1; after the 3rd tick, state RALLY and game_active=1.
- Speed ramp: stay in RALLY for 16 ticks -> speed_level steps 2,3,4,5 and stays 5 at tick 16 (saturates).
- Point handling: point_p2 in RALLY -> score_p2=1, serve_dir=0, game_active=0 for 2 ticks, then SERVE with ball_recentre and speed_level=2.
- Match end: five point_p1 pulses across rallies -> after the 5th, POINT then GAME_OVER, winner=01, score_p1=5; a later start_btn clears scores.
- Collisions and ignores: point_p1 and point_p2 in the same cycle -> only score_p1 increments. A point pulse during SERVE leaves scores unchanged. Reset asserted mid-RALLY -> all outputs return to reset values on the same cycle.
- PONG_PAUSE_EN: pause at countdown=2 -> countdown holds across 5 ticks; resume -> countdown continues 2,1.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encoding for the HUD, winner codes and
// the default match constants used by the match controller, ball datapath
// and HUD.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_RALLY     = 3'd2,
      ST_POINT     = 3'd3,
      ST_GAME_OVER = 3'd4,
      ST_PAUSED    = 3'd5
   } pong_state_e;

   typedef enum logic [1:0] {
      WINNER_NONE = 2'b00,
      WINNER_P1   = 2'b01,
      WINNER_P2   = 2'b10
   } pong_winner_e;

   localparam int unsigned PONG_WIN_SCORE = 5;
   localparam int unsigned PONG_SPEED_MIN = 2;
   localparam int unsigned PONG_SPEED_MAX = 5;

   localparam int unsigned SCORE_W = 4;
   localparam int unsigned SPEED_W = 3;
   localparam int unsigned FRAME_W = 7;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Match controller bus: frame strobe, buttons and point pulses into the
// controller; motion enable, re-centre pulse, scores and HUD status out.
//   master : the surrounding system (drives strobes/buttons, reads status)
//   slave  : pong_match_ctrl
interface pong_match_ctrl_if;
   import pong_pkg::*;

   logic               refresh_tick;
   logic               start_btn;
   logic               pause_btn;
   logic               point_p1;
   logic               point_p2;
   logic               game_active;
   logic               ball_recentre;
   logic               serve_dir;
   logic [SPEED_W-1:0] speed_level;
   logic [SCORE_W-1:0] score_p1;
   logic [SCORE_W-1:0] score_p2;
   logic [FRAME_W-1:0] countdown;
   logic [1:0]         winner;
   logic [2:0]         state_o;

   modport master (
      output refresh_tick, start_btn, pause_btn, point_p1, point_p2,
      input  game_active, ball_recentre, serve_dir, speed_level,
             score_p1, score_p2, countdown, winner, state_o
   );

   modport slave (
      input  refresh_tick, start_btn, pause_btn, point_p1, point_p2,
      output game_active, ball_recentre, serve_dir, speed_level,
             score_p1, score_p2, countdown, winner, state_o
   );

endinterface

// File: rtl/pong_frame_timer.sv
// Loadable frame down-counter, shared by serve countdown and point freeze.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   load_i        : load load_val_i (has priority over tick_i)
//   load_val_i    : value to load
//   tick_i        : advance one frame (already gated by the caller)
//   value_o       : frames remaining
//   expire_o      : tick arriving while value is 1 or 0, so a zero-length
//                   load still lasts exactly one tick
module pong_frame_timer #(
   parameter int unsigned WIDTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             tick_i,
   output logic [WIDTH-1:0] value_o,
   output logic             expire_o
);

   logic [WIDTH-1:0] value_q, value_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) value_q <= '0;
      else       value_q <= value_d;
   end

   always_comb begin
      value_d = value_q;
      if (load_i)
         value_d = load_val_i;
      else if (tick_i && (value_q != '0))
         value_d = value_q - 1'b1;
   end

   assign value_o  = value_q;
   assign expire_o = tick_i && (value_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: owns the match FSM, scores, serve direction and
// ball speed level; gates ball motion and requests ball re-centring.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pong_match_ctrl_if.slave (strobes/buttons in, status out)
// Build option: define PONG_PAUSE_EN to enable the pause_btn / PAUSED state;
// otherwise pause_btn is ignored.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = PONG_WIN_SCORE,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned POINT_FRAMES = 30,
   parameter int unsigned RAMP_FRAMES  = 600,
   parameter int unsigned SPEED_MIN    = PONG_SPEED_MIN,
   parameter int unsigned SPEED_MAX    = PONG_SPEED_MAX
) (
   input  logic              clk,
   input  logic              reset,
   pong_match_ctrl_if.slave  bus
);

   localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);
   localparam logic [SPEED_W-1:0] SPD_LO = SPEED_W'(SPEED_MIN);
   localparam logic [SPEED_W-1:0] SPD_HI = SPEED_W'(SPEED_MAX);

   pong_state_e        state_q, state_d;
   pong_winner_e       winner_q, winner_d;
   logic [SCORE_W-1:0] score_p1_q, score_p1_d;
   logic [SCORE_W-1:0] score_p2_q, score_p2_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic [15:0]        ramp_q, ramp_d;
   logic               dir_q, dir_d;
   logic               recentre_q, recentre_d;
   logic               start_prev_q;
   logic               start_rise;
   logic               pause_rise;

   logic               tmr_load;
   logic [FRAME_W-1:0] tmr_val;
   logic               tmr_tick;
   logic [FRAME_W-1:0] tmr_value;
   logic               tmr_expire;

   assign start_rise = bus.start_btn && !start_prev_q;

`ifdef PONG_PAUSE_EN
   pong_state_e ret_q, ret_d;
   logic        pause_prev_q;

   assign pause_rise = bus.pause_btn && !pause_prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ret_q        <= ST_IDLE;
         pause_prev_q <= 1'b0;
      end else begin
         ret_q        <= ret_d;
         pause_prev_q <= bus.pause_btn;
      end
   end
`else
   assign pause_rise = 1'b0;
`endif

   // A pause edge in SERVE wins over a simultaneous frame tick so the
   // countdown is frozen at the value seen when pause was pressed.
   assign tmr_tick = bus.refresh_tick &&
                     (((state_q == ST_SERVE) && !pause_rise) ||
                      (state_q == ST_POINT));

   pong_frame_timer #(.WIDTH(FRAME_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .tick_i     (tmr_tick),
      .value_o    (tmr_value),
      .expire_o   (tmr_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         winner_q     <= WINNER_NONE;
         score_p1_q   <= '0;
         score_p2_q   <= '0;
         speed_q      <= SPD_LO;
         ramp_q       <= '0;
         dir_q        <= 1'b0;
         recentre_q   <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         winner_q     <= winner_d;
         score_p1_q   <= score_p1_d;
         score_p2_q   <= score_p2_d;
         speed_q      <= speed_d;
         ramp_q       <= ramp_d;
         dir_q        <= dir_d;
         recentre_q   <= recentre_d;
         start_prev_q <= bus.start_btn;
      end
   end

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      score_p1_d = score_p1_q;
      score_p2_d = score_p2_q;
      speed_d    = speed_q;
      ramp_d     = ramp_q;
      dir_d      = dir_q;
      recentre_d = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = '0;
`ifdef PONG_PAUSE_EN
      ret_d      = ret_q;
`endif

      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start_rise) begin
               state_d    = ST_SERVE;
               recentre_d = 1'b1;
               score_p1_d = '0;
               score_p2_d = '0;
               winner_d   = WINNER_NONE;
               speed_d    = SPD_LO;
               tmr_load   = 1'b1;
               tmr_val    = FRAME_W'(SERVE_FRAMES);
            end
         end

         ST_SERVE: begin
            if (pause_rise) begin
`ifdef PONG_PAUSE_EN
               state_d = ST_PAUSED;
               ret_d   = ST_SERVE;
`endif
            end else if (tmr_expire) begin
               state_d = ST_RALLY;
               ramp_d  = '0;
            end
         end

         ST_RALLY: begin
            if (pause_rise) begin
`ifdef PONG_PAUSE_EN
               state_d = ST_PAUSED;
               ret_d   = ST_RALLY;
`endif
            end else if (bus.point_p1) begin
               score_p1_d = score_p1_q + 1'b1;
               dir_d      = 1'b1;
               state_d    = ST_POINT;
               tmr_load   = 1'b1;
               tmr_val    = FRAME_W'(POINT_FRAMES);
            end else if (bus.point_p2) begin
               score_p2_d = score_p2_q + 1'b1;
               dir_d      = 1'b0;
               state_d    = ST_POINT;
               tmr_load   = 1'b1;
               tmr_val    = FRAME_W'(POINT_FRAMES);
            end else if (bus.refresh_tick) begin
               if ((32'(ramp_q) + 32'd1) >= RAMP_FRAMES) begin
                  ramp_d = '0;
                  if (speed_q < SPD_HI)
                     speed_d = speed_q + 1'b1;
               end else begin
                  ramp_d = ramp_q + 1'b1;
               end
            end
         end

         ST_POINT: begin
            if (tmr_expire) begin
               if (score_p1_q >= WIN_S) begin
                  state_d  = ST_GAME_OVER;
                  winner_d = WINNER_P1;
               end else if (score_p2_q >= WIN_S) begin
                  state_d  = ST_GAME_OVER;
                  winner_d = WINNER_P2;
               end else begin
                  state_d    = ST_SERVE;
                  recentre_d = 1'b1;
                  speed_d    = SPD_LO;
                  tmr_load   = 1'b1;
                  tmr_val    = FRAME_W'(SERVE_FRAMES);
               end
            end
         end

`ifdef PONG_PAUSE_EN
         ST_PAUSED: begin
            if (pause_rise)
               state_d = ret_q;
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.game_active   = (state_q == ST_RALLY);
   assign bus.ball_recentre = recentre_q;
   assign bus.serve_dir     = dir_q;
   assign bus.speed_level   = speed_q;
   assign bus.score_p1      = score_p1_q;
   assign bus.score_p2      = score_p2_q;
   assign bus.winner        = winner_q;
   assign bus.state_o       = state_q;
`ifdef PONG_PAUSE_EN
   // A paused serve keeps showing its frozen countdown.
   assign bus.countdown = ((state_q == ST_SERVE) ||
                           ((state_q == ST_PAUSED) && (ret_q == ST_SERVE)))
                          ? tmr_value : '0;
`else
   assign bus.countdown = (state_q == ST_SERVE) ? tmr_value : '0;
`endif

endmodule
